// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, FSM state encoding and queue entry type for the fetch stage
package inst_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - in-order {pc,inst} FIFO between fetch and decode
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   push,
  input  if_entry_t              push_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output if_entry_t              head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (en && push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, single-outstanding memory request FSM and redirect handling
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_valid_in,
  input  logic [INST_W-1:0] mem_data_in,
  output logic              inst_valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              inst_ready_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in
);

  localparam int                CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);

  if_state_e         state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, pc_plus4;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [CNT_W-1:0]  count, post_count;
  logic              push, pop, flush;
  if_entry_t         head;

  assign pop        = inst_valid_out & inst_ready_in & rdy_in & ~redirect_in;
  assign push       = (state == IF_WAIT) & mem_valid_in & ~redirect_in;
  assign flush      = redirect_in;
  assign pc_plus4   = fetch_pc + 32'd4;
  assign post_count = count + CNT_W'(push) - CNT_W'(pop);

  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .en         (rdy_in),
    .flush      (flush),
    .push       (push),
    .push_entry ('{pc: fetch_pc, inst: mem_data_in}),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid_out),
    .head       (head)
  );

  assign inst_out = head.inst;
  assign pc_out   = head.pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_req_nxt  = mem_req_out;
    mem_addr_nxt = mem_addr_out;
    if (redirect_in) begin
      // A word arriving with the redirect is stale; otherwise wait out the in-flight request.
      fetch_pc_nxt = redirect_pc_in & ~32'h3;
      if (state == IF_WAIT || state == IF_DROP) begin
        if (mem_valid_in) begin
          mem_req_nxt = 1'b0;
          state_nxt   = IF_IDLE;
        end else begin
          state_nxt   = IF_DROP;
        end
      end
    end else begin
      unique case (state)
        IF_IDLE: begin
          if (count < DEPTH_C) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = fetch_pc;
            state_nxt    = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_valid_in) begin
            fetch_pc_nxt = pc_plus4;
            if (post_count < DEPTH_C) begin
              mem_addr_nxt = pc_plus4;
            end else begin
              mem_req_nxt = 1'b0;
              state_nxt   = IF_IDLE;
            end
          end
        end
        IF_DROP: begin
          if (mem_valid_in) begin
            mem_req_nxt = 1'b0;
            state_nxt   = IF_IDLE;
          end
        end
        default: state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IF_IDLE;
      fetch_pc     <= RESET_PC;
      mem_req_out  <= 1'b0;
      mem_addr_out <= RESET_PC;
    end else if (rdy_in) begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      mem_req_out  <= mem_req_nxt;
      mem_addr_out <= mem_addr_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized scoreboard bench for inst_fetch
module tb_inst_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  inst_fetch #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .mem_req_out    (mem_req),
    .mem_addr_out   (mem_addr),
    .mem_valid_in   (mem_valid),
    .mem_data_in    (mem_data),
    .inst_valid_out (inst_valid),
    .inst_out       (inst),
    .pc_out         (pc),
    .inst_ready_in  (inst_ready),
    .redirect_in    (redirect),
    .redirect_pc_in (redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // Expected words in decode order; the reference fetch stream is sequential from the last redirect.
  logic [63:0] sb[$];
  logic [31:0] pop_log[$];

  bit          running = 0;
  int          p_ready = 100, p_redir = 0, p_stall = 0;
  int          lat_min = 2, lat_max = 2;
  int          rdy_low_left = 0;
  bit          redir_req = 0, redir_ov = 0;
  logic [31:0] redir_req_pc = 0, redir_ov_pc = 0;

  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  int          pend_delay = 0, pend_epoch = 0, epoch = 0;
  logic [31:0] next_req = RPC;
  bit          prev_rdy = 1;
  logic [31:0] snap [5];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    sb.delete();
    pend     = 0;
    epoch++;
    next_req = RPC;
    prev_rdy = 1;
  endtask

  // Stimulus, memory model and reference model.
  always @(negedge clk) begin
    if (running) begin
      bit          do_r;
      logic [31:0] rpc;
      if (!prev_rdy) begin
        chk("frz_req",   32'(mem_req),    snap[0]);
        chk("frz_addr",  mem_addr,        snap[1]);
        chk("frz_valid", 32'(inst_valid), snap[2]);
        chk("frz_inst",  inst,            snap[3]);
        chk("frz_pc",    pc,              snap[4]);
      end
      snap[0] = 32'(mem_req); snap[1] = mem_addr; snap[2] = 32'(inst_valid);
      snap[3] = inst;         snap[4] = pc;

      chk("valid_vs_model", 32'(inst_valid), 32'(sb.size() != 0));
      if (sb.size() == 0) begin
        chk("empty_inst", inst, 32'h0);
        chk("empty_pc",   pc,   32'h0);
      end
      if (!pend && sb.size() == DEPTH) chk("no_req_when_full", 32'(mem_req), 32'h0);

      if (rdy_low_left > 0) begin
        rdy = 1'b0;
        rdy_low_left--;
      end else begin
        rdy = ($urandom_range(99) >= p_stall);
      end
      inst_ready = ($urandom_range(99) < p_ready);
      mem_valid  = 1'b0;
      redirect   = 1'b0;
      mem_data   = $urandom;
      redirect_pc = $urandom;

      if (rdy) begin
        if (!pend && mem_req) begin
          chk("req_addr", mem_addr, next_req);
          chk("req_room", 32'(sb.size() < DEPTH), 32'h1);
          next_req   = next_req + 32'd4;
          pend       = 1;
          pend_addr  = mem_addr;
          pend_delay = $urandom_range(lat_max, lat_min);
          pend_epoch = epoch;
        end
        if (pend) begin
          if (pend_delay == 0) begin
            mem_valid = 1'b1;
            mem_data  = word_of(pend_addr);
            pend      = 0;
          end else begin
            pend_delay--;
          end
        end
        do_r = 0;
        rpc  = 32'h0;
        if (redir_req) begin
          do_r = 1; rpc = redir_req_pc; redir_req = 0;
        end else if (redir_ov && mem_valid) begin
          do_r = 1; rpc = redir_ov_pc; redir_ov = 0;
        end else if (p_redir > 0 && $urandom_range(999) < p_redir) begin
          do_r = 1;
          rpc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        end
        if (mem_valid && !do_r && pend_epoch == epoch)
          sb.push_back({pend_addr, word_of(pend_addr)});
        if (do_r) begin
          redirect    = 1'b1;
          redirect_pc = rpc;
          sb.delete();
          epoch++;
          next_req = rpc & ~32'h3;
        end
      end
      prev_rdy = rdy;
    end
  end

  // Monitor: consumes the scoreboard whenever decode takes the head.
  always @(negedge clk) begin
    if (running) begin
      #1;
      if (inst_valid && inst_ready && rdy && !redirect) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'h0, 32'h1);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("pop_pc",   pc,   e[63:32]);
          chk("pop_inst", inst, e[31:0]);
        end
        pop_log.push_back(pc);
        pops++;
      end
    end
  end

  initial begin
    int guard;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(mem_req),    32'h0);
    chk("rst_addr",  mem_addr,        RPC);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    pc,              32'h0);
    step(1);
    model_reset();
    rst_n   = 1'b1;
    running = 1;

    // Fill with decode stalled: four requests then silence; pops then resume at 16.
    p_ready = 0; lat_min = 2; lat_max = 2;
    step(30);
    chk("fill_count", 32'(sb.size()), 32'(DEPTH));
    p_ready = 100;
    step(20);

    // Random mix.
    p_ready = 60; lat_min = 0; lat_max = 3; p_redir = 20; p_stall = 10;
    step(300);

    // Redirect to 0x100 while waiting on a slow response.
    p_redir = 0; p_stall = 0; p_ready = 50; lat_min = 3; lat_max = 3;
    step(5);
    redir_req_pc = 32'h100; redir_req = 1;
    guard = 0;
    while (redir_req && guard < 200) begin step(1); guard++; end
    chk("redir_100_issued", 32'(redir_req), 32'h0);
    step(20);

    // Redirect to 0x203 coincident with a response.
    redir_ov_pc = 32'h203; redir_ov = 1;
    guard = 0;
    while (redir_ov && guard < 200) begin step(1); guard++; end
    chk("redir_203_issued", 32'(redir_ov), 32'h0);
    step(20);

    // Wrap-around of the fetch PC.
    p_ready = 100; lat_min = 0; lat_max = 1;
    pop_log.delete();
    redir_req_pc = 32'hFFFF_FFFC; redir_req = 1;
    step(25);
    found = 0;
    for (int i = 0; i + 1 < pop_log.size(); i++) begin
      if (!found && pop_log[i] == 32'hFFFF_FFFC) begin
        found = 1;
        chk("wrap_next_pc", pop_log[i+1], 32'h0);
      end
    end
    chk("wrap_seen", 32'(found), 32'h1);

    // rdy low for 5 cycles with the queue half full.
    p_ready = 0; lat_min = 1; lat_max = 2;
    redir_req_pc = 32'h400; redir_req = 1;
    guard = 0;
    while (sb.size() < DEPTH / 2 && guard < 100) begin step(1); guard++; end
    chk("half_full", 32'(sb.size() >= DEPTH / 2), 32'h1);
    rdy_low_left = 5;
    step(10);
    p_ready = 100;
    step(20);

    // Reset in the middle of a request.
    p_ready = 30; lat_min = 3; lat_max = 3;
    guard = 0;
    while (!pend && guard < 50) begin step(1); guard++; end
    running = 0;
    rst_n = 1'b0; mem_valid = 1'b0; redirect = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("mid_rst_req",   32'(mem_req),    32'h0);
    chk("mid_rst_valid", 32'(inst_valid), 32'h0);
    chk("mid_rst_addr",  mem_addr,        RPC);
    step(1);
    model_reset();
    rst_n   = 1'b1;
    running = 1;

    p_ready = 70; lat_min = 0; lat_max = 3; p_redir = 15; p_stall = 15;
    step(300);

    running = 0;
    chk("liveness", 32'(pops >= 50), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
